// File: rtl/hamming_pkg.sv
// Shared helpers for the SECDED FIFO: parity-width sizing, codeword layout
// queries and a width-generic encoder.
//
// Codeword layout (bit index == Hamming position):
//   bit 0         overall parity (XOR of every other bit)
//   bits 1..N     Hamming positions, N = DW + PH; parity bits sit at powers
//                 of two, data bits fill the rest in ascending order.
package hamming_pkg;

    // Widest data word the generic encoder supports.
    localparam int MAX_DW = 1024;

    // Smallest p with 2**p >= p + dw + 1.
    function automatic int get_parity_width(input int dw);
        int p;
        p = 1;
        for (int i = 0; i < 32; i++) begin
            if ((1 << p) < (p + dw + 1)) begin
                p++;
            end
        end
        return p;
    endfunction

    localparam int MAX_PH = get_parity_width(MAX_DW);
    localparam int MAX_CW = MAX_DW + MAX_PH + 1;

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Hamming position of data bit idx: skip every power of two at or
    // below the running position (powers are visited in ascending order).
    function automatic int data_pos(input int idx);
        int p;
        p = idx + 1;
        for (int k = 0; k < 30; k++) begin
            if ((1 << k) <= p) begin
                p++;
            end
        end
        return p;
    endfunction

    // Encode the low dw bits of data; bits above DW+PH of the result are 0.
    // Parity bits are the bits of the XOR of all positions holding a 1 data
    // bit, which drives the syndrome of the complete codeword to zero.
    function automatic logic [MAX_CW-1:0] secded_encode(input logic [MAX_DW-1:0] data,
                                                        input int dw);
        logic [MAX_CW-1:0] cw;
        int d;
        int n;
        int ph;
        int s;
        cw = '0;
        d  = 0;
        s  = 0;
        ph = get_parity_width(dw);
        n  = dw + ph;
        for (int pos = 1; pos < MAX_CW; pos++) begin
            if ((pos <= n) && !is_pow2(pos)) begin
                cw[pos] = data[d];
                if (data[d]) begin
                    s = s ^ pos;
                end
                d++;
            end
        end
        for (int k = 0; k < MAX_PH; k++) begin
            if (k < ph) begin
                cw[1 << k] = s[k];
            end
        end
        cw[0] = ^cw;
        return cw;
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder: syndrome + overall parity, single-bit
// correction, double-bit detection and error position report.
module hamming_secded_dec
    import hamming_pkg::*;
#(
    parameter int DW = 512,
    parameter int PH = get_parity_width(DW)
) (
    input  logic [DW+PH:0] i_cw,
    output logic [DW-1:0]  o_data,
    output logic           o_sbe,
    output logic           o_dbe,
    output logic [PH-1:0]  o_err_pos
);

    localparam int N = DW + PH;

    logic [PH-1:0] syn;
    logic          par;

    // Syndrome is the XOR of the positions of all set bits; par is odd overall parity.
    always_comb begin
        syn = '0;
        for (int pos = 1; pos <= N; pos++) begin
            if (i_cw[pos]) begin
                syn = syn ^ PH'(pos);
            end
        end
        par = ^i_cw;
    end

    // Odd parity means a single error at position syn (syn == 0: the overall bit itself).
    always_comb begin
        o_sbe     = par;
        o_dbe     = !par && (syn != '0);
        o_err_pos = par ? syn : '0;
    end

    // Extract data bits, flipping the one the syndrome points at on an SBE.
    for (genvar i = 0; i < DW; i++) begin : g_data
        localparam int POS = data_pos(i);
        assign o_data[i] = i_cw[POS] ^ (par && (syn == PH'(POS)));
    end

endmodule

// File: rtl/hamming_secded_fifo.sv
// SECDED-protected FIFO: encodes on write, stores codewords, and decodes the
// head into a registered output stage with valid/ready on both sides.
// Saturating SBE/DBE counters track consumed words; write-side injection
// flips data bits 0/1 of the stored codeword for test.
module hamming_secded_fifo
    import hamming_pkg::*;
#(
    parameter int DW        = 512,
    parameter int FD        = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_wvalid,
    output logic                            o_wready,
    input  logic [DW-1:0]                   i_wdata,
    input  logic [1:0]                      i_err_inj,
    output logic                            o_rvalid,
    input  logic                            i_rready,
    output logic [DW-1:0]                   o_rdata,
    output logic                            o_sbe,
    output logic                            o_dbe,
    output logic [get_parity_width(DW)-1:0] o_err_pos,
    output logic [$clog2(FD+2)-1:0]         o_count,
    input  logic                            i_cnt_clr,
    output logic [ERR_CNT_W-1:0]            o_sbe_cnt,
    output logic [ERR_CNT_W-1:0]            o_dbe_cnt
);

    localparam int PH     = get_parity_width(DW);
    localparam int CW     = DW + PH + 1;
    localparam int AW     = $clog2(FD);
    localparam int MCW    = $clog2(FD + 1);
    localparam int OCW    = $clog2(FD + 2);
    localparam int POS_D0 = data_pos(0);
    localparam int POS_D1 = data_pos(1);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    logic [CW-1:0]        mem_q [FD];
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        rptr_q, rptr_d;
    logic [MCW-1:0]       mem_cnt_q, mem_cnt_d;
    logic                 wready_q, wready_d;
    logic                 rvalid_q, rvalid_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic                 sbe_q, sbe_d;
    logic                 dbe_q, dbe_d;
    logic [PH-1:0]        err_pos_q, err_pos_d;
    logic [ERR_CNT_W-1:0] sbe_cnt_q, sbe_cnt_d;
    logic [ERR_CNT_W-1:0] dbe_cnt_q, dbe_cnt_d;

    logic                 wr_hs;
    logic                 rd_hs;
    logic                 load;
    logic [MAX_DW-1:0]    wdata_ext;
    logic [CW-1:0]        wr_cw;
    logic [DW-1:0]        dec_data;
    logic                 dec_sbe;
    logic                 dec_dbe;
    logic [PH-1:0]        dec_err_pos;

    // Encode the write word and apply the injection flips on data bits 0 and 1.
    always_comb begin
        wdata_ext         = '0;
        wdata_ext[DW-1:0] = i_wdata;
        wr_cw             = CW'(secded_encode(wdata_ext, DW));
        wr_cw[POS_D0]     = wr_cw[POS_D0] ^ i_err_inj[0];
        wr_cw[POS_D1]     = wr_cw[POS_D1] ^ i_err_inj[1];
    end

    hamming_secded_dec #(
        .DW (DW),
        .PH (PH)
    ) u_dec (
        .i_cw      (mem_q[rptr_q]),
        .o_data    (dec_data),
        .o_sbe     (dec_sbe),
        .o_dbe     (dec_dbe),
        .o_err_pos (dec_err_pos)
    );

    // Handshakes, pointer/occupancy update, output-stage load and counters.
    always_comb begin
        wr_hs = i_wvalid && wready_q;
        rd_hs = rvalid_q && i_rready;
        load  = (!rvalid_q || rd_hs) && (mem_cnt_q != '0);

        wptr_d = wr_hs ? wptr_q + AW'(1) : wptr_q;
        rptr_d = load  ? rptr_q + AW'(1) : rptr_q;

        case ({wr_hs, load})
            2'b10:   mem_cnt_d = mem_cnt_q + MCW'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - MCW'(1);
            default: mem_cnt_d = mem_cnt_q;
        endcase
        // Registered from next occupancy only, so no path from i_rready.
        wready_d = (mem_cnt_d != MCW'(FD));

        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        sbe_d     = sbe_q;
        dbe_d     = dbe_q;
        err_pos_d = err_pos_q;
        if (load) begin
            rvalid_d  = 1'b1;
            rdata_d   = dec_data;
            sbe_d     = dec_sbe;
            dbe_d     = dec_dbe;
            err_pos_d = dec_err_pos;
        end else if (rd_hs) begin
            rvalid_d  = 1'b0;
        end

        sbe_cnt_d = sbe_cnt_q;
        dbe_cnt_d = dbe_cnt_q;
        if (i_cnt_clr) begin
            sbe_cnt_d = '0;
            dbe_cnt_d = '0;
        end else if (rd_hs) begin
            if (sbe_q) sbe_cnt_d = sat_inc(sbe_cnt_q);
            if (dbe_q) dbe_cnt_d = sat_inc(dbe_cnt_q);
        end
    end

    // Codeword storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_hs) begin
            mem_q[wptr_q] <= wr_cw;
        end
    end

    // Control, output stage and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_cnt_q <= '0;
            wready_q  <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            sbe_q     <= 1'b0;
            dbe_q     <= 1'b0;
            err_pos_q <= '0;
            sbe_cnt_q <= '0;
            dbe_cnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mem_cnt_q <= mem_cnt_d;
            wready_q  <= wready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            sbe_q     <= sbe_d;
            dbe_q     <= dbe_d;
            err_pos_q <= err_pos_d;
            sbe_cnt_q <= sbe_cnt_d;
            dbe_cnt_q <= dbe_cnt_d;
        end
    end

    assign o_wready  = wready_q;
    assign o_rvalid  = rvalid_q;
    assign o_rdata   = rdata_q;
    assign o_sbe     = sbe_q;
    assign o_dbe     = dbe_q;
    assign o_err_pos = err_pos_q;
    assign o_count   = OCW'(mem_cnt_q) + OCW'(rvalid_q);
    assign o_sbe_cnt = sbe_cnt_q;
    assign o_dbe_cnt = dbe_cnt_q;

endmodule
